// File: rtl/noc_ctrl_pkg.sv
// Shared definitions for the NIC port scheduler: FSM state encoding, NIC register
// select codes and the default data-path width.
package noc_ctrl_pkg;

  // Default NIC data-path (packet) width.
  localparam int unsigned DefaultDw = 64;

  // NIC register select codes driven on nic_addr.
  localparam logic [1:0] ADDR_DATA     = 2'b00;
  localparam logic [1:0] ADDR_IN_FULL  = 2'b01;
  localparam logic [1:0] ADDR_WRITE    = 2'b10;
  localparam logic [1:0] ADDR_OUT_FULL = 2'b11;

  // Scheduler FSM. Access states (StRdInf, StRdData, StRdOutf, StWr) each issue exactly
  // one NIC access; the check/capture states consume the registered NIC read data.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdInf   = 3'd1,
    StChkInf  = 3'd2,
    StRdData  = 3'd3,
    StCap     = 3'd4,
    StRdOutf  = 3'd5,
    StChkOutf = 3'd6,
    StWr      = 3'd7
  } nic_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector, bit k = requester k
//   adv_i         : a grant was issued this cycle; advance the pointer
//   adv_idx_i     : requester that received that grant
//   win_o         : index of the current winner (0 when nothing is requested)
// The pointer names the preferred requester and only matters when both request.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       adv_idx_i,
  output logic       win_o
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // After a grant, prefer the requester that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = ~adv_idx_i;
    end
  end

  always_comb begin
    unique case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = ptr_q;
      default: win_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/nic_port_sched.sv
// NIC port scheduler: time-shares a single-ported NIC register interface between a
// receive path (poll in_full, read data_reg into a holding register) and two transmit
// requesters (poll out_full, write the round-robin winner's packet).
//   clk, reset          : clock, asynchronous active-low reset
//   tx_req, tx_data0/1  : per-requester send request and packet
//   tx_gnt              : one-cycle pulse when requester k's packet is written
//   rx_valid, rx_data,
//   rx_ready            : received packet holding register with valid/ready handshake
//   nic_addr, nic_di,
//   nic_en, nic_we      : NIC register access (select, write data, enable, write enable)
//   nic_do              : NIC read data, valid the cycle after nic_en
module nic_port_sched
  import noc_ctrl_pkg::*;
#(
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    tx_req,
  input  logic [DW-1:0] tx_data0,
  input  logic [DW-1:0] tx_data1,
  output logic [1:0]    tx_gnt,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  input  logic          rx_ready,
  output logic [1:0]    nic_addr,
  output logic [DW-1:0] nic_di,
  output logic          nic_en,
  output logic          nic_we,
  input  logic [DW-1:0] nic_do
);

  nic_state_e    state_q, state_d;
  logic          svc_q, svc_d;        // favoured IDLE slot: 0 = RX, 1 = TX
  logic          sel_q, sel_d;        // requester latched for the current TX sequence
  logic          rx_valid_q, rx_valid_d;
  logic [DW-1:0] rx_data_q, rx_data_d;

  logic          rx_elig, tx_elig, take_rx, take_tx;
  logic          arb_win;

  // RX is blocked while a packet is still held, so data_reg is never read over it.
  assign rx_elig = ~rx_valid_q;
  assign tx_elig = |tx_req;
  assign take_rx = rx_elig & (~svc_q | ~tx_elig);
  assign take_tx = tx_elig & (svc_q | ~rx_elig);

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk),
    .rst_ni    (reset),
    .req_i     (tx_req),
    .adv_i     (state_q == StWr),
    .adv_idx_i (sel_q),
    .win_o     (arb_win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      svc_q      <= 1'b0;
      sel_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      svc_q      <= svc_d;
      sel_q      <= sel_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    svc_d      = svc_q;
    sel_d      = sel_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (take_rx) begin
          state_d = StRdInf;
          svc_d   = ~svc_q;
        end else if (take_tx) begin
          state_d = StRdOutf;
          svc_d   = ~svc_q;
          sel_d   = arb_win;
        end
      end
      StRdInf:   state_d = StChkInf;
      StChkInf:  state_d = nic_do[0] ? StRdData : StIdle;
      StRdData:  state_d = StCap;
      StCap: begin
        rx_data_d  = nic_do;
        rx_valid_d = 1'b1;
        state_d    = StIdle;
      end
      StRdOutf:  state_d = StChkOutf;
      // A withdrawn request or a full NIC abandons the send without touching the pointer.
      StChkOutf: state_d = (!nic_do[0] && tx_req[sel_q]) ? StWr : StIdle;
      StWr:      state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    nic_en   = 1'b0;
    nic_we   = 1'b0;
    nic_addr = ADDR_DATA;
    nic_di   = '0;
    tx_gnt   = 2'b00;
    unique case (state_q)
      StRdInf: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_FULL;
      end
      StRdData: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_DATA;
      end
      StRdOutf: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_FULL;
      end
      StWr: begin
        nic_en   = 1'b1;
        nic_we   = 1'b1;
        nic_addr = ADDR_WRITE;
        nic_di   = sel_q ? tx_data1 : tx_data0;
        tx_gnt   = sel_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_nic_port_sched.sv
// Self-checking bench for nic_port_sched. A behavioural NIC register file answers the
// DUT's accesses; a transaction-level reference model schedules, by absolute cycle
// number, the NIC accesses, grants and receive hand-offs the scheduling rules demand,
// and every cycle the DUT outputs are compared against that schedule.
module tb_nic_port_sched;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    tx_req;
  logic [DW-1:0] tx_data0, tx_data1;
  logic [1:0]    tx_gnt;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic [1:0]    nic_addr;
  logic [DW-1:0] nic_di;
  logic          nic_en, nic_we;
  logic [DW-1:0] nic_do;

  always #5 clk = ~clk;

  nic_port_sched #(.DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_req   (tx_req),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .tx_gnt   (tx_gnt),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .nic_addr (nic_addr),
    .nic_di   (nic_di),
    .nic_en   (nic_en),
    .nic_we   (nic_we),
    .nic_do   (nic_do)
  );

  // Behavioural NIC: registered read port; flag reads carry junk in the upper bits.
  logic          nic_in_full, nic_out_full;
  logic [DW-1:0] nic_data_reg, nic_junk;

  always @(posedge clk) begin
    if (!reset) begin
      nic_do <= '0;
    end else if (nic_en && !nic_we) begin
      case (nic_addr)
        2'b00:   nic_do <= nic_data_reg;
        2'b01:   nic_do <= {nic_junk[DW-1:1], nic_in_full};
        2'b11:   nic_do <= {nic_junk[DW-1:1], nic_out_full};
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state. *_at fields hold absolute cycle numbers (-1 = none).
  int            m_next_dec, m_rx_poll_at, m_rx_rd_at, m_set_valid_at, m_tx_poll_at, m_tx_chk_at;
  bit            m_svc_tx, m_ptr, m_sel, m_of_val, m_rx_valid, m_clr_pend;
  logic [DW-1:0] m_rx_data, m_pend_data;
  logic [1:0]    m_last_gnt;
  int            n_gnt, n_rx, polls, phase, base;
  bit            rst_done;

  // Expected NIC/grant outputs per cycle, ring-indexed by cycle number.
  logic          e_en [8];
  logic          e_we [8];
  logic [1:0]    e_addr [8];
  logic [1:0]    e_gnt [8];
  logic [DW-1:0] e_di [8];

  task automatic clear_slot(input int s);
    e_en[s] = 1'b0; e_we[s] = 1'b0; e_addr[s] = 2'b00; e_gnt[s] = 2'b00; e_di[s] = '0;
  endtask

  task automatic sched(input int at, input logic [1:0] addr, input logic we,
                       input logic [DW-1:0] di, input logic [1:0] gnt);
    int s;
    s = at % 8;
    e_en[s] = 1'b1; e_addr[s] = addr; e_we[s] = we; e_di[s] = di; e_gnt[s] = gnt;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) clear_slot(i);
    m_next_dec = -1; m_rx_poll_at = -1; m_rx_rd_at = -1; m_set_valid_at = -1;
    m_tx_poll_at = -1; m_tx_chk_at = -1;
    m_svc_tx = 1'b0; m_ptr = 1'b0; m_sel = 1'b0; m_of_val = 1'b0;
    m_rx_valid = 1'b0; m_clr_pend = 1'b0; m_rx_data = '0; m_pend_data = '0;
    m_last_gnt = 2'b00;
  endtask

  // One cycle of the reference model, called on the falling edge.
  task automatic step();
    int s;
    bit rx_el, tx_el, go_rx, go_tx;
    s = cyc % 8;
    if (m_clr_pend) m_rx_valid = 1'b0;
    m_clr_pend = 1'b0;
    if (cyc == m_set_valid_at) begin
      m_rx_valid = 1'b1;
      m_rx_data  = m_pend_data;
      n_rx++;
    end

    check_eq("nic_en", nic_en, e_en[s]);
    check_eq("nic_we", nic_we, e_we[s]);
    check_eq("nic_addr", nic_addr, e_addr[s]);
    check_eq("nic_di", nic_di, e_di[s]);
    check_eq("tx_gnt", tx_gnt, e_gnt[s]);
    check_eq("rx_valid", rx_valid, m_rx_valid);
    check_eq("rx_data", rx_data, m_rx_data);
    m_last_gnt = e_gnt[s];
    if (e_gnt[s] != 2'b00) n_gnt++;
    clear_slot(s);

    // in_full poll this cycle: its answer decides whether data_reg is read.
    if (cyc == m_rx_poll_at) begin
      if (nic_in_full) begin
        sched(cyc + 2, 2'b00, 1'b0, '0, 2'b00);
        m_rx_rd_at = cyc + 2;
        m_next_dec = cyc + 4;
      end else begin
        m_next_dec = cyc + 2;
      end
    end
    if (cyc == m_rx_rd_at) begin
      m_pend_data    = nic_data_reg;
      m_set_valid_at = cyc + 2;
    end
    if (cyc == m_tx_poll_at) begin
      m_of_val = nic_out_full;
      if (phase == 2) polls++;
    end
    if (cyc == m_tx_chk_at) begin
      if (!m_of_val && tx_req[m_sel]) begin
        sched(cyc + 1, 2'b10, 1'b1, m_sel ? tx_data1 : tx_data0, m_sel ? 2'b10 : 2'b01);
        m_ptr      = !m_sel;
        m_next_dec = cyc + 2;
      end else begin
        m_next_dec = cyc + 1;
      end
    end
    if (cyc == m_next_dec) begin
      rx_el = !m_rx_valid;
      tx_el = (tx_req != 2'b00);
      if (!m_svc_tx) begin
        go_rx = rx_el;
        go_tx = !rx_el && tx_el;
      end else begin
        go_tx = tx_el;
        go_rx = !tx_el && rx_el;
      end
      if (go_rx) begin
        sched(cyc + 1, 2'b01, 1'b0, '0, 2'b00);
        m_rx_poll_at = cyc + 1;
        m_svc_tx     = !m_svc_tx;
      end else if (go_tx) begin
        m_sel = (tx_req == 2'b11) ? m_ptr : tx_req[1];
        sched(cyc + 1, 2'b11, 1'b0, '0, 2'b00);
        m_tx_poll_at = cyc + 1;
        m_tx_chk_at  = cyc + 2;
        m_svc_tx     = !m_svc_tx;
      end else begin
        m_next_dec = cyc + 1;
      end
    end
    m_clr_pend = m_rx_valid && rx_ready;
  endtask

  task automatic new_data(input int k);
    if (k == 0) tx_data0 = {$urandom, $urandom};
    else        tx_data1 = {$urandom, $urandom};
  endtask

  // Stimulus for the cycle just started; requests drop only on their own grant.
  task automatic drive();
    int  rel;
    bit  raise [2];
    bit  keep [2];
    rel = cyc - base;
    nic_junk = {$urandom, $urandom};
    raise[0] = 1'b0; raise[1] = 1'b0; keep[0] = 1'b0; keep[1] = 1'b0;
    nic_in_full = 1'b0; nic_out_full = 1'b0; rx_ready = 1'b1;
    nic_data_reg = {$urandom, $urandom};
    case (phase)
      0: begin
        raise[0] = ($urandom % 4) == 0;
        raise[1] = ($urandom % 4) == 0;
        nic_in_full  = ($urandom % 2) == 0;
        nic_out_full = ($urandom % 3) == 0;
        rx_ready     = ($urandom % 2) == 0;
      end
      1: begin
        raise[0] = 1'b1; raise[1] = 1'b1; keep[0] = 1'b1; keep[1] = 1'b1;
      end
      2: begin
        raise[0]     = 1'b1;
        nic_out_full = (polls < 5);
      end
      3: begin
        nic_in_full  = 1'b1;
        nic_data_reg = 64'h1234;
        rx_ready     = (rel >= 830);
      end
      4: begin
        raise[0] = 1'b1; keep[0] = 1'b1;
        nic_in_full = 1'b1;
      end
      default: begin
        raise[0] = 1'b1; keep[0] = 1'b1;
        if (rst_done) begin
          raise[1] = 1'b1; keep[1] = 1'b1;
        end
      end
    endcase
    for (int k = 0; k < 2; k++) begin
      if (tx_req[k] && m_last_gnt[k]) begin
        if (keep[k]) new_data(k);
        else tx_req[k] = 1'b0;
      end else if (!tx_req[k] && raise[k]) begin
        tx_req[k] = 1'b1;
        new_data(k);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_nic_en"}, nic_en, 1'b0);
    check_eq({tag, "_nic_we"}, nic_we, 1'b0);
    check_eq({tag, "_nic_addr"}, nic_addr, 2'b00);
    check_eq({tag, "_nic_di"}, nic_di, '0);
    check_eq({tag, "_tx_gnt"}, tx_gnt, 2'b00);
    check_eq({tag, "_rx_valid"}, rx_valid, 1'b0);
  endtask

  initial begin
    int gnt_mark;
    reset = 1'b1; tx_req = 2'b00; tx_data0 = '0; tx_data1 = '0; rx_ready = 1'b0;
    nic_in_full = 1'b0; nic_out_full = 1'b0; nic_data_reg = '0; nic_junk = '0;
    n_gnt = 0; n_rx = 0; polls = 0; phase = 0; rst_done = 1'b0; gnt_mark = 0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_idle_outputs("por");
    check_eq("por_rx_data", rx_data, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc  = 10;
    base = cyc;
    reset = 1'b1;
    m_next_dec = cyc;
    step();

    for (int rel = 1; rel <= 1100; rel++) begin
      @(posedge clk);
      cyc++;
      if (rel < 600)      phase = 0;
      else if (rel < 700) phase = 1;
      else if (rel < 780) phase = 2;
      else if (rel < 880) phase = 3;
      else if (rel < 980) phase = 4;
      else                phase = 5;
      if (rel == 780) polls = 0;
      if (rel == 980) gnt_mark = n_gnt;
      #1 drive();
      @(negedge clk);
      step();
      // Reset while the DUT is in CHK_OUTF with a write due next cycle.
      if (phase == 5 && !rst_done && n_gnt > gnt_mark && cyc == m_tx_chk_at) begin
        reset = 1'b0;
        #1 check_idle_outputs("rst_mid");
        model_reset();
        @(posedge clk);
        cyc++;
        #1 check_idle_outputs("rst_hold");
        @(negedge clk);
        tx_req = 2'b11;
        new_data(0);
        new_data(1);
        rst_done   = 1'b1;
        reset      = 1'b1;
        m_next_dec = cyc;
        step();
      end
    end

    check_eq("mid_seq_reset_hit", rst_done, 1'b1);
    check_eq("saw_grants", n_gnt > 0, 1'b1);
    check_eq("saw_rx", n_rx > 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nic_port_sched.md
NIC_PORT_SCHED -- requirements
Module: nic_port_sched

Interface
REQ-001 Parameter DW, default 64, NIC data-path width (packet width).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 tx_req  in  2  per-requester send request; bit k belongs to requester k.
REQ-005 tx_data0  in  DW  packet offered by requester 0.
REQ-006 tx_data1  in  DW  packet offered by requester 1.
REQ-007 tx_gnt  out  2  one-cycle pulse; bit k means requester k's packet was written to the NIC.
REQ-008 rx_valid  out  1  received packet held on rx_data.
REQ-009 rx_data  out  DW  received packet.
REQ-010 rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
REQ-011 nic_addr  out  2  NIC register select: 00 data_reg, 01 in_full, 10 write_data, 11 out_full.
REQ-012 nic_di  out  DW  NIC write data.
REQ-013 nic_en  out  1  NIC access enable.
REQ-014 nic_we  out  1  NIC write enable.
REQ-015 nic_do  in  DW  NIC read data; valid in the cycle after the cycle nic_en was high (registered NIC output).

Function
REQ-016 FSM states: IDLE, RD_INF, CHK_INF, RD_DATA, CAP, RD_OUTF, CHK_OUTF, WR; exactly one NIC access per access state (RD_INF, RD_DATA, RD_OUTF, WR).
REQ-017 Access-state outputs: RD_INF addr 01, en 1; RD_DATA addr 00, en 1; RD_OUTF addr 11, en 1; WR addr 10, en 1, we 1, nic_di = latched requester's packet.
REQ-018 In every other state, nic_en = nic_we = 0, nic_addr = 00 and nic_di = 0.
REQ-019 IDLE service slot (svc bit) alternates between RX and TX.
- RX slot eligible only when rx_valid = 0.
- TX slot eligible only when tx_req != 0.
- If the favoured slot is ineligible, take the other slot.
- If neither slot is eligible, remain in IDLE.
- svc toggles on every IDLE exit.
REQ-020 RX sequence: IDLE -> RD_INF -> CHK_INF.
- CHK_INF: nic_do[0] = 1 -> RD_DATA; nic_do[0] = 0 -> IDLE.
- RD_DATA -> CAP.
- CAP: rx_data <= nic_do, rx_valid <= 1, -> IDLE.
REQ-021 RX timing: with IDLE in cycle n, RD_INF is cycle n+1 and CAP is cycle n+4; rx_valid is first high in cycle n+5.
REQ-022 rx_valid and rx_data hold until the cycle rx_valid & rx_ready is sampled; rx_valid clears on the next edge.
REQ-023 No NIC data_reg read occurs while rx_valid = 1, so an undrained packet is never overwritten.
REQ-024 TX sequence: IDLE latches the winner of the 2-way round-robin over tx_req into sel; IDLE -> RD_OUTF -> CHK_OUTF.
- CHK_OUTF: nic_do[0] = 0 and tx_req[sel] = 1 -> WR.
- CHK_OUTF otherwise -> IDLE, with no grant and the round-robin pointer unchanged.
REQ-025 WR: tx_gnt[sel] = 1 for exactly that cycle; the round-robin pointer then favours the other requester; -> IDLE.
REQ-026 TX timing: with IDLE in cycle n, the write and tx_gnt occur in cycle n+3.
REQ-027 Requesters hold tx_req and tx_data stable until tx_gnt. Deasserting tx_req before WR withdraws the request: WR is skipped and no grant is issued.
REQ-028 Round-robin: pointer = preferred requester; with both requesting, the pointer side wins; with one requesting, it wins regardless of the pointer.
REQ-029 tx_gnt is never two-hot and is never asserted outside WR.

Reset
REQ-030 Reset assertion immediately forces: state IDLE, svc = RX, round-robin pointer = 0, sel = 0, rx_valid = 0, rx_data = 0, tx_gnt = 0, nic_en = nic_we = 0, nic_addr = 00, nic_di = 0.
REQ-031 Reset mid-sequence abandons the access with no grant and no rx_valid; a packet already latched in rx_data is discarded.
REQ-032 The first IDLE decision occurs on the first rising edge after reset deassertion.

Structure
REQ-033 Shared package noc_ctrl_pkg holds:
- the FSM state encoding;
- NIC address constants ADDR_DATA = 00, ADDR_IN_FULL = 01, ADDR_WRITE = 10, ADDR_OUT_FULL = 11;
- the default DW.
REQ-034 Sub-module rr_arb2 (2-way round-robin with pointer-update input) is instantiated once; all other logic stays in nic_port_sched.

Verification
REQ-035 Single send: tx_req = 01, tx_data0 = 0xABCD...; NIC out_full = 0 -> nic_we/addr 10 with that data and tx_gnt = 01 exactly 3 cycles after IDLE.
REQ-036 Contention: tx_req = 11 held continuously, NIC never full -> grants alternate 01, 10, 01, 10.
REQ-037 Backpressure: out_full = 1 for 5 polls then 0 -> no grant and no write during the full polls; exactly one write follows the first 0.
REQ-038 Receive: NIC in_full = 1 with data_reg = 0x1234 -> rx_valid = 1, rx_data = 0x1234. With rx_ready held 0 for 10 cycles, rx_data is unchanged and no data_reg read occurs; rx_ready = 1 clears rx_valid next cycle.
REQ-039 Mixed traffic: tx_req = 01 and in_full = 1 continuously -> IDLE exits alternate RX and TX sequences, with no starvation of either.
REQ-040 Reset mid-sequence: reset asserted during CHK_OUTF -> NIC outputs are zero immediately, no tx_gnt is issued, and the pointer is 0 after release.
